seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Passive receiver for the multiplexed seven-segment display bus: samples the active-low anode strobes and segment cathodes, waits for each scanned pattern to settle, decodes the lit-segment glyph back to a hex nibble, and rebuilds the four displayed digits. It sits on the board-side pins, alongside the display scanner/driver, as a loopback monitor and self-check for the display path. It also flags scan-order and multi-anode faults.

## Interface
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is captured; legal range 1..255.
- div_clock  input  1  sampling clock; must run at least STABLE_CYCLES+4 times faster than the scan step rate.
- reset  input  1  asynchronous, active-low reset: asserted at 0, all state cleared immediately.
- anode  input  4  active-low digit strobes; bit 0 = rightmost digit, bit 3 = leftmost.
- seg  input  7  active-low cathodes; bit 0 = a through bit 6 = g.
- dp  input  1  active-low decimal point.
- clear_error  input  1  synchronous clear of scan_error.
- digits  output  16  captured nibbles; digit i in [4i+3:4i].
- digit_valid  output  4  bit i = digit i holds a recognized glyph from its latest capture.
- dp_out  output  4  bit i = decimal point lit on latest capture of digit i (active-high).
- frame_done  output  1  one-cycle pulse when a complete in-order frame (0,1,2,3) has been captured.
- scan_error  output  1  sticky fault flag.

## Operation
- Input path: all 12 inputs pass through a 2-flop synchronizer. Downstream logic sees only synchronized values.
- Stability filter: a saturating counter tracks consecutive cycles with an unchanged synchronized vector. Any change resets it. A capture event fires exactly once per settled pattern, on the cycle the count reaches STABLE_CYCLES. There is no re-fire while the vector is held.
- Capture event classification, by anode:
  - All ones (blank): ignored; no output change.
  - Exactly one zero, at index i: digit i update.
    - Glyph recognized: digits[i] set to nibble, digit_valid[i]=1, dp_out[i] set.
    - Glyph unrecognized: digits[i] unchanged, digit_valid[i]=0, dp_out[i] set.
  - Two or more zeros: scan_error set; no digit update; sequencer returns to RESYNC.
- Glyph table (lit segments → nibble); any other pattern is unrecognized:
  - 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc
  - 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg
- Sequencer FSM states: RESYNC, EXPECT1, EXPECT2, EXPECT3.
  - RESYNC: a capture of digit 0 → EXPECT1. Captures of digits 1–3 are stored but cause no transition.
  - EXPECTk: a capture of digit k → EXPECT(k+1). From EXPECT3, a capture of digit 3 → pulse frame_done, go to RESYNC.
  - EXPECTk, capture of digit 0: restart; stay at EXPECT1, no error.
  - EXPECTk, capture of any other digit: set scan_error, go to RESYNC. The digit is still stored.
- frame_done fires whether or not all four glyphs were recognized.
- scan_error: set on a multi-anode capture or an order violation; cleared by clear_error. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values: digits=16'h0000, digit_valid=4'b0000, dp_out=4'b0000, frame_done=0, scan_error=0, FSM=RESYNC, stability counter=0, synchronizers all ones.
- Latency: with inputs changed just before edge 0 and then held, digits, digit_valid and dp_out update on rising edge STABLE_CYCLES+3. frame_done asserts on that same edge for the digit-3 capture.
- Patterns held fewer than STABLE_CYCLES+1 synchronized cycles (ghosting/transients) are never captured.
- Reset mid-frame clears everything asynchronously. A full 0,1,2,3 sequence is required before the next frame_done.
- Counter saturates at STABLE_CYCLES; no wrap-around during long holds.

## Test plan
- Nominal frame: with STABLE_CYCLES=4, drive anode 1110/1101/1011/0111 carrying glyphs 1 (seg=7'b1111001), 2 (7'b0100100), A (7'b0001000), 0 (7'b1000000), each held 10 cycles → digits=16'h0A21, digit_valid=4'hF, one frame_done pulse, scan_error=0.
- Latency/filter:
  - Hold anode=1110, seg=7'b0000000 for 6 cycles → digits[3:0]=8 on edge 7, not earlier.
  - A 4-cycle pulse of the same pattern → no update.
- Unrecognized glyph and dp: anode=1101, seg=7'b1111110, dp=0 held → digit_valid[1]=0, dp_out[1]=1, digits[7:4] unchanged.
- Multi-anode fault: anode=1100 held → scan_error=1, no digit change. Then clear_error pulse → 0. Then clear_error coincident with a new fault → stays 1.
- Order violation: digits 0 then 2 → scan_error=1, no frame_done. The next clean 0,1,2,3 frame → frame_done pulses.
- Reset mid-frame: capture digits 0,1, pull reset low one cycle → all outputs at reset values. Then digits 2,3 only → no frame_done.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Passive monitor for a multiplexed seven-segment bus: rebuilds the four displayed
// hex digits from settled anode/segment patterns and flags scan-order faults.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        i_div_clock,
    input  logic        i_reset,
    input  logic [3:0]  i_anode,
    input  logic [6:0]  i_seg,
    input  logic        i_dp,
    input  logic        i_clear_error,
    output logic [15:0] o_digits,
    output logic [3:0]  o_digit_valid,
    output logic [3:0]  o_dp_out,
    output logic        o_frame_done,
    output logic        o_scan_error
);

    // state     | meaning
    // S_RESYNC  | waiting for a digit-0 capture to start a frame
    // S_EXPECT1 | digit 0 seen, waiting for digit 1
    // S_EXPECT2 | digits 0,1 seen, waiting for digit 2
    // S_EXPECT3 | digits 0..2 seen, waiting for digit 3
    typedef enum logic [1:0] {
        S_RESYNC  = 2'd0,
        S_EXPECT1 = 2'd1,
        S_EXPECT2 = 2'd2,
        S_EXPECT3 = 2'd3
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

    logic [11:0] r_sync1;
    logic [11:0] r_sync2;
    logic [11:0] r_prev;
    logic [7:0]  r_stable_cnt;
    logic        r_fired;
    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_digits;
    logic [3:0]  r_digit_valid;
    logic [3:0]  r_dp_out;
    logic        r_frame_done;
    logic        r_scan_error;

    logic        w_changed;
    logic        w_capture;
    logic [3:0]  w_anode;
    logic [6:0]  w_seg_lit;
    logic        w_dp_lit;
    logic [3:0]  w_nibble;
    logic        w_glyph_ok;
    logic        w_single;
    logic        w_blank;
    logic        w_multi;
    logic [1:0]  w_idx;
    logic [1:0]  w_state_idx;
    logic        w_digit_cap;
    logic        w_multi_cap;
    logic        w_frame_set;
    logic        w_order_err;
    logic        w_err_set;

    // Vector layout: {dp, seg[6:0], anode[3:0]}; idle bus (all off) resets to all ones.
    always_ff @(posedge i_div_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= {i_dp, i_seg, i_anode};
            r_sync2 <= r_sync1;
        end
    end

    assign w_changed = (r_sync2 != r_prev);
    // r_fired keeps a held pattern from being captured again once the count saturates.
    assign w_capture = (r_stable_cnt == CNT_MAX) && !r_fired;

    always_ff @(posedge i_div_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_prev       <= '1;
            r_stable_cnt <= '0;
            r_fired      <= 1'b0;
        end else begin
            r_prev <= r_sync2;
            if (w_changed) begin
                r_stable_cnt <= '0;
                r_fired      <= 1'b0;
            end else begin
                if (r_stable_cnt != CNT_MAX) r_stable_cnt <= r_stable_cnt + 8'd1;
                if (w_capture) r_fired <= 1'b1;
            end
        end
    end

    assign w_anode   = r_prev[3:0];
    assign w_seg_lit = ~r_prev[10:4];
    assign w_dp_lit  = ~r_prev[11];

    always_comb begin
        w_nibble   = 4'h0;
        w_glyph_ok = 1'b1;
        case (w_seg_lit)
            7'h3F:   w_nibble = 4'h0;
            7'h06:   w_nibble = 4'h1;
            7'h5B:   w_nibble = 4'h2;
            7'h4F:   w_nibble = 4'h3;
            7'h66:   w_nibble = 4'h4;
            7'h6D:   w_nibble = 4'h5;
            7'h7D:   w_nibble = 4'h6;
            7'h07:   w_nibble = 4'h7;
            7'h7F:   w_nibble = 4'h8;
            7'h6F:   w_nibble = 4'h9;
            7'h77:   w_nibble = 4'hA;
            7'h7C:   w_nibble = 4'hB;
            7'h39:   w_nibble = 4'hC;
            7'h5E:   w_nibble = 4'hD;
            7'h79:   w_nibble = 4'hE;
            7'h71:   w_nibble = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_single = 1'b0;
        w_idx    = 2'd0;
        case (w_anode)
            4'b1110: begin w_single = 1'b1; w_idx = 2'd0; end
            4'b1101: begin w_single = 1'b1; w_idx = 2'd1; end
            4'b1011: begin w_single = 1'b1; w_idx = 2'd2; end
            4'b0111: begin w_single = 1'b1; w_idx = 2'd3; end
            default: w_single = 1'b0;
        endcase
    end

    assign w_blank     = (w_anode == 4'b1111);
    assign w_multi     = !w_blank && !w_single;
    assign w_digit_cap = w_capture && w_single;
    assign w_multi_cap = w_capture && w_multi;
    assign w_state_idx = r_state;

    always_ff @(posedge i_div_clock or negedge i_reset) begin
        if (!i_reset) r_state <= S_RESYNC;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_multi_cap) begin
            w_state_next = S_RESYNC;
        end else if (w_digit_cap) begin
            if (r_state == S_RESYNC) begin
                if (w_idx == 2'd0) w_state_next = S_EXPECT1;
            end else if (w_idx == w_state_idx) begin
                w_state_next = (r_state == S_EXPECT3) ? S_RESYNC : state_t'(w_state_idx + 2'd1);
            end else if (w_idx == 2'd0) begin
                w_state_next = S_EXPECT1;
            end else begin
                w_state_next = S_RESYNC;
            end
        end
    end

    always_comb begin
        w_frame_set = w_digit_cap && (r_state == S_EXPECT3) && (w_idx == 2'd3);
        w_order_err = w_digit_cap && (r_state != S_RESYNC) && (w_idx != 2'd0)
                      && (w_idx != w_state_idx);
        w_err_set   = w_order_err || w_multi_cap;
    end

    always_ff @(posedge i_div_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_digits      <= '0;
            r_digit_valid <= '0;
            r_dp_out      <= '0;
            r_frame_done  <= 1'b0;
            r_scan_error  <= 1'b0;
        end else begin
            r_frame_done <= w_frame_set;
            if (w_err_set)          r_scan_error <= 1'b1;
            else if (i_clear_error) r_scan_error <= 1'b0;
            if (w_digit_cap) begin
                r_dp_out[w_idx]      <= w_dp_lit;
                r_digit_valid[w_idx] <= w_glyph_ok;
                if (w_glyph_ok) r_digits[{w_idx, 2'b00} +: 4] <= w_nibble;
            end
        end
    end

    assign o_digits      = r_digits;
    assign o_digit_valid = r_digit_valid;
    assign o_dp_out      = r_dp_out;
    assign o_frame_done  = r_frame_done;
    assign o_scan_error  = r_scan_error;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scenarios plus a randomized
// scan stream compared against a pattern-level reference model.
module tb_seven_seg_capture;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        clear_error;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  dp_out;
    logic        frame_done;
    logic        scan_error;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0;

    string tab [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    seven_seg_capture #(.STABLE_CYCLES(S)) dut (
        .i_div_clock   (clk),
        .i_reset       (rst_n),
        .i_anode       (anode),
        .i_seg         (seg),
        .i_dp          (dp),
        .i_clear_error (clear_error),
        .o_digits      (digits),
        .o_digit_valid (digit_valid),
        .o_dp_out      (dp_out),
        .o_frame_done  (frame_done),
        .o_scan_error  (scan_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done === 1'b1) frame_cnt++;

    function automatic logic [6:0] lit_of(input string s);
        logic [6:0] v = '0;
        for (int i = 0; i < s.len(); i++) begin
            int k = int'(s[i]) - 97;
            v[k] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [6:0] seg_of(input int n);
        return ~lit_of(tab[n]);
    endfunction

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        anode = a;
        seg   = s;
        dp    = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        anode = 4'hF;
        seg   = 7'h7F;
        dp    = 1'b1;
        clear_error = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hold(4'hF, 7'h7F, 1'b1, 10);
    endtask

    task automatic test_reset();
        hold(4'b1110, seg_of(3), 1'b0, 12);
        rst_n = 1'b0;
        #2;
        checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h exp 0000", digits); end
        checks++; if (digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %b exp 0000", digit_valid); end
        checks++; if (dp_out !== 4'h0) begin errors++; $display("FAIL reset_dp got %b exp 0000", dp_out); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame got %b exp 0", frame_done); end
        checks++; if (scan_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", scan_error); end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_nominal();
        int f0;
        do_reset();
        f0 = frame_cnt;
        hold(4'b1110, 7'b1111001, 1'b1, 10);
        hold(4'b1101, 7'b0100100, 1'b1, 10);
        hold(4'b1011, 7'b0001000, 1'b1, 10);
        hold(4'b0111, 7'b1000000, 1'b1, 10);
        checks++; if (digits !== 16'h0A21) begin errors++; $display("FAIL nominal_digits got %h exp 0a21", digits); end
        checks++; if (digit_valid !== 4'hF) begin errors++; $display("FAIL nominal_valid got %b exp 1111", digit_valid); end
        checks++; if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL nominal_frames got %0d exp 1", frame_cnt - f0); end
        checks++; if (scan_error !== 1'b0) begin errors++; $display("FAIL nominal_err got %b exp 0", scan_error); end
        checks++; if (dp_out !== 4'h0) begin errors++; $display("FAIL nominal_dp got %b exp 0000", dp_out); end
    endtask

    task automatic test_latency_filter();
        do_reset();
        anode = 4'b1110; seg = 7'b0000000; dp = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (digits[3:0] !== 4'h0) begin errors++; $display("FAIL lat_edge5 got %h exp 0", digits[3:0]); end
        anode = 4'hF;
        @(negedge clk);
        checks++; if (digits[3:0] !== 4'h0) begin errors++; $display("FAIL lat_edge6 got %h exp 0", digits[3:0]); end
        @(negedge clk);
        checks++; if (digits[3:0] !== 4'h8) begin errors++; $display("FAIL lat_edge7 got %h exp 8", digits[3:0]); end
        checks++; if (digit_valid[0] !== 1'b1) begin errors++; $display("FAIL lat_valid got %b exp 1", digit_valid[0]); end
        hold(4'hF, 7'h7F, 1'b1, 10);
        hold(4'b1110, 7'b1111001, 1'b1, S);
        hold(4'hF, 7'h7F, 1'b1, 12);
        checks++; if (digits[3:0] !== 4'h8) begin errors++; $display("FAIL glitch_digit got %h exp 8", digits[3:0]); end
    endtask

    task automatic test_unrecognized();
        do_reset();
        hold(4'b1101, seg_of(5), 1'b1, 10);
        checks++; if (digits[7:4] !== 4'h5 || digit_valid[1] !== 1'b1) begin
            errors++; $display("FAIL unrec_setup got %h/%b exp 5/1", digits[7:4], digit_valid[1]); end
        hold(4'hF, 7'h7F, 1'b1, 4);
        hold(4'b1101, 7'b1111110, 1'b0, 10);
        checks++; if (digit_valid[1] !== 1'b0) begin errors++; $display("FAIL unrec_valid got %b exp 0", digit_valid[1]); end
        checks++; if (dp_out[1] !== 1'b1) begin errors++; $display("FAIL unrec_dp got %b exp 1", dp_out[1]); end
        checks++; if (digits[7:4] !== 4'h5) begin errors++; $display("FAIL unrec_keep got %h exp 5", digits[7:4]); end
        checks++; if (scan_error !== 1'b0) begin errors++; $display("FAIL unrec_err got %b exp 0", scan_error); end
    endtask

    task automatic test_multi_anode();
        do_reset();
        hold(4'b1100, seg_of(8), 1'b1, 10);
        checks++; if (scan_error !== 1'b1) begin errors++; $display("FAIL multi_err got %b exp 1", scan_error); end
        checks++; if (digits !== 16'h0000 || digit_valid !== 4'h0) begin
            errors++; $display("FAIL multi_nochange got %h/%b exp 0000/0000", digits, digit_valid); end
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        checks++; if (scan_error !== 1'b0) begin errors++; $display("FAIL clear_err got %b exp 0", scan_error); end
        hold(4'hF, 7'h7F, 1'b1, 10);
        anode = 4'b0101; seg = seg_of(1); dp = 1'b1;
        repeat (S + 3) @(negedge clk);
        checks++; if (scan_error !== 1'b0) begin errors++; $display("FAIL pre_coincide got %b exp 0", scan_error); end
        clear_error = 1'b1;
        @(negedge clk);
        clear_error = 1'b0;
        checks++; if (scan_error !== 1'b1) begin errors++; $display("FAIL coincide_err got %b exp 1", scan_error); end
    endtask

    task automatic test_order_violation();
        int f0;
        do_reset();
        f0 = frame_cnt;
        hold(4'b1110, seg_of(0), 1'b1, 10);
        hold(4'b1011, seg_of(2), 1'b1, 10);
        checks++; if (scan_error !== 1'b1) begin errors++; $display("FAIL order_err got %b exp 1", scan_error); end
        checks++; if (frame_cnt - f0 !== 0) begin errors++; $display("FAIL order_noframe got %0d exp 0", frame_cnt - f0); end
        checks++; if (digits[11:8] !== 4'h2) begin errors++; $display("FAIL order_stored got %h exp 2", digits[11:8]); end
        hold(4'b1110, seg_of(4), 1'b1, 10);
        hold(4'b1101, seg_of(5), 1'b1, 10);
        hold(4'b1011, seg_of(6), 1'b1, 10);
        hold(4'b0111, seg_of(7), 1'b1, 10);
        checks++; if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL order_recover got %0d exp 1", frame_cnt - f0); end
        checks++; if (digits !== 16'h7654) begin errors++; $display("FAIL order_digits got %h exp 7654", digits); end
    endtask

    task automatic test_reset_mid_frame();
        int f0;
        do_reset();
        hold(4'b1110, seg_of(3), 1'b0, 10);
        hold(4'b1101, seg_of(7), 1'b1, 10);
        rst_n = 1'b0;
        anode = 4'hF; seg = 7'h7F; dp = 1'b1;
        #1;
        checks++; if (digits !== 16'h0000 || digit_valid !== 4'h0 || dp_out !== 4'h0) begin
            errors++; $display("FAIL midrst_outputs got %h/%b/%b exp 0000/0000/0000", digits, digit_valid, dp_out); end
        @(negedge clk);
        rst_n = 1'b1;
        f0 = frame_cnt;
        hold(4'hF, 7'h7F, 1'b1, 5);
        hold(4'b1011, seg_of(9), 1'b1, 10);
        hold(4'b0111, seg_of(12), 1'b1, 10);
        checks++; if (frame_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_noframe got %0d exp 0", frame_cnt - f0); end
        checks++; if (digits !== 16'hC900 || digit_valid !== 4'b1100) begin
            errors++; $display("FAIL midrst_digits got %h/%b exp c900/1100", digits, digit_valid); end
    endtask

    task automatic test_random_stream();
        logic [3:0]  m_dig [4];
        logic [3:0]  m_val;
        logic [3:0]  m_dp;
        logic        m_err;
        int          m_pos;
        int          m_frames;
        int          f0;
        logic [11:0] prev_vec;
        do_reset();
        f0 = frame_cnt;
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_val = '0; m_dp = '0; m_err = 1'b0; m_pos = 0; m_frames = 0;
        prev_vec = {1'b1, 7'h7F, 4'hF};
        for (int step = 0; step < 80; step++) begin
            logic [3:0] a;
            logic [6:0] s;
            logic       d;
            logic       long_hold;
            int         n;
            int         r;
            do begin
                r = $urandom_range(0, 9);
                if (r == 0) a = 4'hF;
                else if (r == 1) begin
                    do a = 4'($urandom_range(0, 15)); while ($countones(~a) < 2);
                end else a = ~(4'b0001 << $urandom_range(0, 3));
                if ($urandom_range(0, 4) == 0) s = 7'($urandom_range(0, 127));
                else s = seg_of($urandom_range(0, 15));
                d = 1'($urandom_range(0, 1));
            end while ({d, s, a} == prev_vec);
            prev_vec  = {d, s, a};
            long_hold = ($urandom_range(0, 3) != 0);
            n = long_hold ? $urandom_range(8, 14) : $urandom_range(1, S);
            if (long_hold && $urandom_range(0, 7) == 0) begin
                clear_error = 1'b1;
                hold(a, s, d, 1);
                clear_error = 1'b0;
                m_err = 1'b0;
                hold(a, s, d, n - 1);
            end else begin
                hold(a, s, d, n);
            end
            if (long_hold) begin
                if ($countones(~a) == 1) begin
                    int idx = 0;
                    int nib = -1;
                    for (int k = 0; k < 4; k++) if (a[k] == 1'b0) idx = k;
                    for (int g = 0; g < 16; g++) if (lit_of(tab[g]) == ~s) nib = g;
                    if (nib >= 0) begin m_dig[idx] = 4'(nib); m_val[idx] = 1'b1; end
                    else m_val[idx] = 1'b0;
                    m_dp[idx] = ~d;
                    if (m_pos == 0) begin
                        if (idx == 0) m_pos = 1;
                    end else if (idx == m_pos) begin
                        if (idx == 3) begin m_frames++; m_pos = 0; end
                        else m_pos++;
                    end else if (idx == 0) begin
                        m_pos = 1;
                    end else begin
                        m_err = 1'b1; m_pos = 0;
                    end
                end else if (a != 4'hF) begin
                    m_err = 1'b1; m_pos = 0;
                end
                checks++; if (digits !== {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}) begin
                    errors++; $display("FAIL rand_digits step %0d got %h exp %h", step, digits,
                                       {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}); end
                checks++; if (digit_valid !== m_val) begin
                    errors++; $display("FAIL rand_valid step %0d got %b exp %b", step, digit_valid, m_val); end
                checks++; if (dp_out !== m_dp) begin
                    errors++; $display("FAIL rand_dp step %0d got %b exp %b", step, dp_out, m_dp); end
                checks++; if (scan_error !== m_err) begin
                    errors++; $display("FAIL rand_err step %0d got %b exp %b", step, scan_error, m_err); end
                checks++; if (frame_cnt - f0 !== m_frames) begin
                    errors++; $display("FAIL rand_frames step %0d got %0d exp %0d", step, frame_cnt - f0, m_frames); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        anode = 4'hF;
        seg   = 7'h7F;
        dp    = 1'b1;
        clear_error = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_nominal();
        test_latency_filter();
        test_unrecognized();
        test_multi_anode();
        test_order_violation();
        test_reset_mid_frame();
        test_random_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end

endmodule
